// File: rtl/elm_mac_accumulator_pkg.sv
// Shared definitions for the ELM hidden-neuron MAC stage: default widths,
// FSM state encoding and the guard-bit sizing helper.
package elm_mac_accumulator_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 16;
    localparam int DEFAULT_VEC_LEN    = 4;

    // FSM state encoding, kept as plain constants so older tools and
    // netlist-level debug see stable binary values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Extra integer bits needed to sum n products without overflow.
    function automatic int guard_bits(input int n);
        return $clog2(n);
    endfunction

    // Full internal accumulator width: bias width plus product width plus
    // guard bits, so no intermediate sum can overflow.
    function automatic int sum_width(input int acc_w, input int data_w, input int vec_len);
        return acc_w + 2 * data_w + guard_bits(vec_len);
    endfunction

endpackage

// File: rtl/elm_sat_shift.sv
// Arithmetic right shift followed by signed saturation to OUT_WIDTH.
// Purely combinational; shared with the output-layer accumulator.
module elm_sat_shift
    import elm_mac_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int SHIFT     = 0
) (
    input  logic [IN_WIDTH-1:0]  sum_in,
    output logic [OUT_WIDTH-1:0] sat_out,
    output logic                 sat_flag
);

    logic signed [IN_WIDTH-1:0]   shifted;
    logic [IN_WIDTH-OUT_WIDTH:0]  upper;

    // Shift, then clamp when the bits above the output sign bit disagree.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        shifted  = $signed(sum_in) >>> SHIFT;
        upper    = shifted[IN_WIDTH-1:OUT_WIDTH-1];
        sat_flag = !((&upper) || !(|upper));
        if (!sat_flag) begin
            sat_out = shifted[OUT_WIDTH-1:0];
        end else if (shifted[IN_WIDTH-1]) begin
            sat_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/elm_mac_accumulator.sv
// ELM hidden-neuron dot product: bias + sum(x*w) over VEC_LEN beats,
// shifted and saturated to ACC_WIDTH, presented with a one-cycle load strobe
// for the downstream accumulator register.
module elm_mac_accumulator
    import elm_mac_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int VEC_LEN    = DEFAULT_VEC_LEN,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ACC_WIDTH-1:0]  bias_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  load_out,
    output logic                  sat_flag,
    output logic                  busy
);

    localparam int SUM_WIDTH  = sum_width(ACC_WIDTH, DATA_WIDTH, VEC_LEN);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH  = guard_bits(VEC_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(VEC_LEN - 1);

    logic [1:0]                   state;
    logic [SUM_WIDTH-1:0]         acc;
    logic [CNT_WIDTH-1:0]         cnt;
    logic signed [PROD_WIDTH-1:0] product;
    logic [SUM_WIDTH-1:0]         bias_ext;
    logic [SUM_WIDTH-1:0]         product_ext;
    logic [SUM_WIDTH-1:0]         next_sum;
    logic                         beat;
    logic                         last_beat;
    logic [ACC_WIDTH-1:0]         sat_value;
    logic                         sat_hit;

    assign product     = $signed(x_in) * $signed(w_in);
    assign bias_ext    = {{(SUM_WIDTH-ACC_WIDTH){bias_in[ACC_WIDTH-1]}}, bias_in};
    assign product_ext = {{(SUM_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    assign next_sum    = acc + product_ext;

    assign beat      = (state == ST_ACCUM) && in_valid;
    assign last_beat = beat && (cnt == LAST_BEAT);

    assign in_ready = (state == ST_ACCUM);
    assign load_out = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);

    // The sum including the final beat is narrowed here so the result can be
    // registered on the same edge that accepts that beat.
    elm_sat_shift #(
        .IN_WIDTH  (SUM_WIDTH),
        .OUT_WIDTH (ACC_WIDTH),
        .SHIFT     (FRAC_SHIFT)
    ) u_sat_shift (
        .sum_in   (next_sum),
        .sat_out  (sat_value),
        .sat_flag (sat_hit)
    );

    // Control FSM with the running sum and beat counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (rst) begin
            // NOTE: the running sum is cleared as well so an aborted
            // operation never leaves a partial sum behind.
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        cnt   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc <= next_sum;
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register: captured on the final beat, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out  <= '0;
            sat_flag <= 1'b0;
        end else if (last_beat) begin
            acc_out  <= sat_value;
            sat_flag <= sat_hit;
        end
    end

endmodule

// File: tb/tb_elm_mac_accumulator.sv
// Randomised bench for elm_mac_accumulator. Two instances share the stimulus:
// one with FRAC_SHIFT=0 and one with FRAC_SHIFT=2, both compared against an
// integer reference model of bias + sum(x*w), shifted and clamped.
module tb_elm_mac_accumulator;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] bias_in;
    logic          in_valid;
    logic [DW-1:0] x_in;
    logic [DW-1:0] w_in;

    logic [AW-1:0] acc0, acc2;
    logic          load0, load2, sat0, sat2, rdy0, rdy2, busy0, busy2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_loads = 0;
    int load_seen = 0;
    int load_double = 0;
    logic prev_load = 1'b0;

    int cur_bias;
    int cur_x[VL];
    int cur_w[VL];

    always #5 clk = ~clk;

    elm_mac_accumulator #(
        .DATA_WIDTH (DW), .ACC_WIDTH (AW), .VEC_LEN (VL), .FRAC_SHIFT (0)
    ) u_dut0 (
        .clk (clk), .rst (rst), .start (start), .bias_in (bias_in),
        .in_valid (in_valid), .in_ready (rdy0), .x_in (x_in), .w_in (w_in),
        .acc_out (acc0), .load_out (load0), .sat_flag (sat0), .busy (busy0)
    );

    elm_mac_accumulator #(
        .DATA_WIDTH (DW), .ACC_WIDTH (AW), .VEC_LEN (VL), .FRAC_SHIFT (2)
    ) u_dut2 (
        .clk (clk), .rst (rst), .start (start), .bias_in (bias_in),
        .in_valid (in_valid), .in_ready (rdy2), .x_in (x_in), .w_in (w_in),
        .acc_out (acc2), .load_out (load2), .sat_flag (sat2), .busy (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, arithmetic shift, clamp.
    function automatic void model(input int shift, output logic [AW-1:0] val, output logic sat);
        longint s;
        s = longint'(cur_bias);
        for (int i = 0; i < VL; i++) s += longint'(cur_x[i] * cur_w[i]);
        s = s >>> shift;
        if (s > 32767) begin
            val = 16'h7fff;
            sat = 1'b1;
        end else if (s < -32768) begin
            val = 16'h8000;
            sat = 1'b1;
        end else begin
            val = s[AW-1:0];
            sat = 1'b0;
        end
    endfunction

    // Load strobe monitor: counts pulses and back-to-back highs on both DUTs.
    always @(negedge clk) begin
        if (load0) begin
            load_seen++;
            if (prev_load) load_double++;
        end
        if (load0 !== load2) load_double++;
        prev_load = load0;
    end

    task automatic set_vec(input int b, input int x0, input int x1, input int x2, input int x3,
                           input int w0, input int w1, input int w2, input int w3);
        cur_bias = b;
        cur_x[0] = x0; cur_x[1] = x1; cur_x[2] = x2; cur_x[3] = x3;
        cur_w[0] = w0; cur_w[1] = w1; cur_w[2] = w2; cur_w[3] = w3;
    endtask

    task automatic rand_vec();
        cur_bias = $signed(16'($urandom));
        for (int i = 0; i < VL; i++) begin
            cur_x[i] = $signed(8'($urandom));
            cur_w[i] = $signed(8'($urandom));
        end
    endtask

    // One full operation; called with the clock just past a rising edge.
    task automatic run_op(input int min_bub, input int max_bub, input bit mid_start,
                          input bit valid_in_start, input bit start_in_done);
        logic [AW-1:0] e0, e2;
        logic s0, s2;
        int nb;
        model(0, e0, s0);
        model(2, e2, s2);
        start    = 1'b1;
        bias_in  = AW'(cur_bias);
        in_valid = valid_in_start;
        x_in     = 8'h7f;
        w_in     = 8'h7f;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", 32'(busy0), 32'd1);
        check("ready_in_accum", 32'(rdy0 & rdy2), 32'd1);
        for (int i = 0; i < VL; i++) begin
            nb = $urandom_range(max_bub, min_bub);
            for (int b = 0; b < nb; b++) begin
                in_valid = 1'b0;
                x_in     = DW'($urandom);
                w_in     = DW'($urandom);
                start    = mid_start;
                bias_in  = AW'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            x_in     = DW'(cur_x[i]);
            w_in     = DW'(cur_w[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < VL - 1) check("no_early_load", 32'(load0 | load2), 32'd0);
        end
        check("load_in_done", 32'(load0 & load2), 32'd1);
        check("ready_low_done", 32'(rdy0 | rdy2), 32'd0);
        check("acc_shift0", 32'(acc0), 32'(e0));
        check("sat_shift0", 32'(sat0), 32'(s0));
        check("acc_shift2", 32'(acc2), 32'(e2));
        check("sat_shift2", 32'(sat2), 32'(s2));
        exp_loads++;
        start   = start_in_done;
        bias_in = AW'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check("load_single", 32'(load0), 32'd0);
        check("idle_after_done", 32'(busy0 | busy2), 32'd0);
        check("acc_held", 32'(acc0), 32'(e0));
        check("acc2_held", 32'(acc2), 32'(e2));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_acc0"}, 32'(acc0), 32'd0);
        check({tag, "_acc2"}, 32'(acc2), 32'd0);
        check({tag, "_flags"}, 32'({sat0, sat2, load0, load2}), 32'd0);
        check({tag, "_busy_rdy"}, 32'({busy0, busy2, rdy0, rdy2}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bias_in = '0; in_valid = 1'b0; x_in = '0; w_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic sum: 20 unshifted, 5 with shift 2.
        set_vec(10, 1, 2, 3, 4, 1, 1, 1, 1);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);

        // Signed mix: -60.
        set_vec(-5, -3, 5, -7, 2, 4, -2, 3, -6);
        run_op(0, 0, 1'b0, 1'b1, 1'b0);

        // Saturation in both directions.
        set_vec(0, 127, 127, 127, 127, 127, 127, 127, 127);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);
        set_vec(0, -128, -128, -128, -128, 127, 127, 127, 127);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);

        // Bubbles, start pulsed mid-op, start held in DONE, in_valid in start cycle.
        set_vec(10, 1, 2, 3, 4, 1, 1, 1, 1);
        run_op(1, 3, 1'b1, 1'b1, 1'b1);

        // Shift rounding toward -inf: -7 >>> 2 = -2.
        set_vec(-7, 1, 0, 0, 0, 0, 0, 0, 0);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);

        // Reset after two beats discards the op and clears outputs.
        set_vec(10, 1, 2, 3, 4, 1, 1, 1, 1);
        start = 1'b1; bias_in = AW'(cur_bias);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_in = DW'(cur_x[i]); w_in = DW'(cur_w[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("mid_reset");
        set_vec(-5, -3, 5, -7, 2, 4, -2, 3, -6);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);

        // Random operations with random bubbles and control noise.
        for (int n = 0; n < 40; n++) begin
            rand_vec();
            run_op(0, 2, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(posedge clk); #1;
        check("load_pulse_count", 32'(load_seen), 32'(exp_loads));
        check("load_double_or_skew", 32'(load_double), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
